// File: rtl/macro_result_collector.sv
// Receive side of the CIM macro handshake: captures per-channel ADC results, adds bias,
// applies ReLU with saturation, buffers them and re-paces them as an output feature-map stream.
module macro_result_collector #(
  parameter int OUT_CH       = 64,
  parameter int ADC_W        = 8,
  parameter int FM_OUT_WIDTH = 28,
  parameter int FIFO_DEPTH   = 4,
  parameter int OUT_PERIOD   = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         mode_in,
  input  logic                         vs_in,
  input  logic                         latch_to_macro,
  input  logic                         enable_to_macro,
  input  logic [OUT_CH-1:0][ADC_W-1:0] macro_data,
  input  logic                         bias_load,
  input  logic [OUT_CH-1:0][15:0]      bias_in,
  output logic                         data_out_valid,
  output logic [OUT_CH-1:0][15:0]      data_out,
  output logic                         vs_out,
  output logic                         frame_done,
  output logic                         overflow
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int PACE_W    = $clog2(OUT_PERIOD + 1);
  localparam int PIX_TOTAL = FM_OUT_WIDTH * FM_OUT_WIDTH;
  localparam int PIX_W     = $clog2(PIX_TOTAL + 1);

  typedef logic [OUT_CH-1:0][15:0] word_t;
  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, STREAM = 2'd2} state_t;

  // Sign-extend both operands to 17 bits so the sum can never wrap, then clamp to [0, 32767].
  function automatic logic [15:0] relu_sat(input logic [ADC_W-1:0] r, input logic [15:0] b);
    logic [16:0] s;
    s = {{(17 - ADC_W){r[ADC_W-1]}}, r} + {b[15], b};
    if (s[16])      return 16'h0000;
    else if (s[15]) return 16'h7FFF;
    else            return s[15:0];
  endfunction

  logic                         latch_d;
  logic [OUT_CH-1:0][ADC_W-1:0] raw;
  logic                         raw_vld;
  word_t                        bias;
  word_t                        result;
  logic                         res_vld;

  word_t                        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [CNT_W-1:0]             count;
  logic [PACE_W-1:0]            pace_cnt;
  logic [PIX_W-1:0]             pix_cnt, pix_next;
  state_t                       state;

  logic flush, capture, full, push, pop, push_ok;

  assign flush    = vs_in | ~mode_in;
  assign capture  = mode_in & ~latch_to_macro & latch_d & enable_to_macro;
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign push     = res_vld;
  assign pop      = ((state == SYNC) || (state == STREAM)) && (pace_cnt == '0) && (count != '0);
  assign push_ok  = push & (~full | pop);
  assign pix_next = ((state == SYNC) ? '0 : pix_cnt) + PIX_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                      bias <= '0;
    else if (!mode_in && bias_load) bias <= bias_in;
  end

  // Capture on the falling edge of the latch window (E0), compute at E1; result is pushed at E2.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      latch_d <= 1'b0;
      raw     <= '0;
      raw_vld <= 1'b0;
      result  <= '0;
      res_vld <= 1'b0;
    end else begin
      latch_d <= latch_to_macro;
      if (flush) begin
        raw     <= '0;
        raw_vld <= 1'b0;
        result  <= '0;
        res_vld <= 1'b0;
      end else begin
        raw_vld <= capture;
        if (capture) raw <= macro_data;
        res_vld <= raw_vld;
        if (raw_vld) begin
          for (int c = 0; c < OUT_CH; c++) result[c] <= relu_sat(raw[c], bias[c]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: FIFO storage is cleared on reset too, so every entry holds a defined value from reset on.
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      pace_cnt       <= '0;
      pix_cnt        <= '0;
      state          <= IDLE;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      vs_out         <= 1'b0;
      frame_done     <= 1'b0;
      overflow       <= 1'b0;
    end else if (flush) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      pace_cnt       <= '0;
      pix_cnt        <= '0;
      state          <= IDLE;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      vs_out         <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      data_out_valid <= 1'b0;
      vs_out         <= 1'b0;
      frame_done     <= 1'b0;
      if (pace_cnt != '0) pace_cnt <= pace_cnt - PACE_W'(1);

      if (push_ok) begin
        mem[wr_ptr] <= result;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end else if (push) begin
        overflow <= 1'b1;
      end

      if (push_ok && !pop)      count <= count + CNT_W'(1);
      else if (!push_ok && pop) count <= count - CNT_W'(1);

      case (state)
        IDLE: begin
          if (count != '0) begin
            state  <= SYNC;
            vs_out <= 1'b1;
          end
        end
        SYNC: begin
          state   <= STREAM;
          pix_cnt <= '0;
        end
        STREAM:  ;
        default: state <= IDLE;
      endcase

      // A pop in SYNC is the first pixel of the frame; the frame closes on its last pixel.
      if (pop) begin
        data_out       <= mem[rd_ptr];
        rd_ptr         <= rd_ptr + PTR_W'(1);
        data_out_valid <= 1'b1;
        pace_cnt       <= PACE_W'(OUT_PERIOD - 1);
        if (pix_next == PIX_W'(PIX_TOTAL)) begin
          frame_done <= 1'b1;
          pix_cnt    <= '0;
          state      <= IDLE;
        end else begin
          pix_cnt    <= pix_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_macro_result_collector.sv
// Directed bench for macro_result_collector: one instance paced at 8 cycles, one at 32 cycles,
// both with 4x4 output frames and 4 channels, sharing the same stimulus.
module tb_macro_result_collector;

  localparam int OUT_CH = 4;
  localparam int ADC_W  = 8;

  typedef logic [OUT_CH-1:0][ADC_W-1:0] adc_vec_t;
  typedef logic [OUT_CH-1:0][15:0]      pix_vec_t;

  logic     clk, rstn, mode_in, vs_in, latch_to_macro, enable_to_macro, bias_load;
  adc_vec_t macro_data;
  pix_vec_t bias_in;

  logic     f_valid, f_vs, f_fd, f_ovf;
  pix_vec_t f_data;
  logic     o_valid, o_vs, o_fd, o_ovf;
  pix_vec_t o_data;

  int n_cmp = 0;
  int n_bad = 0;

  macro_result_collector #(
    .OUT_CH(OUT_CH), .ADC_W(ADC_W), .FM_OUT_WIDTH(4), .FIFO_DEPTH(4), .OUT_PERIOD(8)
  ) dut_f (
    .clk(clk), .rstn(rstn), .mode_in(mode_in), .vs_in(vs_in),
    .latch_to_macro(latch_to_macro), .enable_to_macro(enable_to_macro),
    .macro_data(macro_data), .bias_load(bias_load), .bias_in(bias_in),
    .data_out_valid(f_valid), .data_out(f_data), .vs_out(f_vs),
    .frame_done(f_fd), .overflow(f_ovf)
  );

  macro_result_collector #(
    .OUT_CH(OUT_CH), .ADC_W(ADC_W), .FM_OUT_WIDTH(4), .FIFO_DEPTH(4), .OUT_PERIOD(32)
  ) dut_o (
    .clk(clk), .rstn(rstn), .mode_in(mode_in), .vs_in(vs_in),
    .latch_to_macro(latch_to_macro), .enable_to_macro(enable_to_macro),
    .macro_data(macro_data), .bias_load(bias_load), .bias_in(bias_in),
    .data_out_valid(o_valid), .data_out(o_data), .vs_out(o_vs),
    .frame_done(o_fd), .overflow(o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event recorder for whichever instance sel points at (0 = dut_f, 1 = dut_o).
  logic        sel = 1'b0;
  logic        mon_en = 1'b0;
  logic        m_valid, m_vs, m_fd;
  logic [15:0] m_data0;
  int          cyc, vs_cnt, vs_cyc, v_cnt, first_v_cyc, last_v_cyc, min_gap, fd_cnt, fd_cyc;
  logic [15:0] vq [$];

  assign m_valid = sel ? o_valid   : f_valid;
  assign m_vs    = sel ? o_vs      : f_vs;
  assign m_fd    = sel ? o_fd      : f_fd;
  assign m_data0 = sel ? o_data[0] : f_data[0];

  always @(negedge clk) begin
    if (!mon_en) begin
      cyc <= 0; vs_cnt <= 0; vs_cyc <= 0; v_cnt <= 0; first_v_cyc <= 0;
      last_v_cyc <= 0; min_gap <= 1000000; fd_cnt <= 0; fd_cyc <= -1;
      vq.delete();
    end else begin
      cyc <= cyc + 1;
      if (m_vs) begin vs_cnt <= vs_cnt + 1; vs_cyc <= cyc; end
      if (m_fd) begin fd_cnt <= fd_cnt + 1; fd_cyc <= cyc; end
      if (m_valid) begin
        if (v_cnt == 0) first_v_cyc <= cyc;
        else if (cyc - last_v_cyc < min_gap) min_gap <= cyc - last_v_cyc;
        last_v_cyc <= cyc;
        v_cnt      <= v_cnt + 1;
        vq.push_back(m_data0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs;
    mode_in = 1'b0; vs_in = 1'b0; latch_to_macro = 1'b0; enable_to_macro = 1'b0;
    bias_load = 1'b0; macro_data = '0; bias_in = '0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rstn = 1'b0;
    idle_inputs();
    tick(2);
    rstn = 1'b1;
  endtask

  // Loading bias needs mode_in=0, which also flushes the stream side.
  task automatic load_bias(input pix_vec_t b);
    @(negedge clk);
    mode_in = 1'b0; bias_load = 1'b1; bias_in = b;
    @(negedge clk);
    bias_load = 1'b0; mode_in = 1'b1;
  endtask

  // One latch window: high for one edge, low at the next (the capture edge).
  task automatic window(input adc_vec_t d);
    @(negedge clk);
    latch_to_macro = 1'b1; enable_to_macro = 1'b1; macro_data = d;
    @(negedge clk);
    latch_to_macro = 1'b0;
  endtask

  task automatic mon_start(input logic which);
    @(negedge clk);
    mon_en = 1'b0; sel = which;
    tick(2);
    mon_en = 1'b1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    idle_inputs();
    tick(2);
    n_cmp++; if (f_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", f_valid); end
    n_cmp++; if (f_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", f_data); end
    n_cmp++; if (f_vs !== 1'b0) begin n_bad++; $display("FAIL reset_vs: got %b want 0", f_vs); end
    n_cmp++; if (f_fd !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", f_fd); end
    n_cmp++; if (o_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", o_ovf); end
    rstn = 1'b1;
    tick(3);
    n_cmp++; if ({f_valid, f_vs, f_fd, f_ovf} !== 4'b0) begin
      n_bad++; $display("FAIL post_reset_flags: got %b want 0000", {f_valid, f_vs, f_fd, f_ovf});
    end
  endtask

  task automatic test_bias_relu;
    pix_vec_t b, exp;
    adc_vec_t d;
    b = '0; b[0] = 16'd100; b[1] = 16'hFFFB;
    d[0] = 8'hF6; d[1] = 8'h03; d[2] = 8'h80; d[3] = 8'h7F;
    exp[0] = 16'd90; exp[1] = 16'd0; exp[2] = 16'd0; exp[3] = 16'd127;
    load_bias(b);
    window(d);
    tick(4);
    n_cmp++; if (f_vs !== 1'b1) begin n_bad++; $display("FAIL first_vs_latency: got %b want 1", f_vs); end
    n_cmp++; if (f_valid !== 1'b0) begin n_bad++; $display("FAIL valid_before_vs: got %b want 0", f_valid); end
    tick(1);
    n_cmp++; if (f_valid !== 1'b1) begin n_bad++; $display("FAIL first_valid_latency: got %b want 1", f_valid); end
    n_cmp++; if (f_vs !== 1'b0) begin n_bad++; $display("FAIL vs_one_cycle: got %b want 0", f_vs); end
    for (int c = 0; c < OUT_CH; c++) begin
      n_cmp++;
      if (f_data[c] !== exp[c]) begin
        n_bad++; $display("FAIL bias_relu_ch%0d: got %0d want %0d", c, f_data[c], exp[c]);
      end
    end
    tick(2);
    n_cmp++; if (f_data !== exp) begin n_bad++; $display("FAIL data_hold: got %h want %h", f_data, exp); end
  endtask

  task automatic test_saturation;
    pix_vec_t b, exp;
    adc_vec_t d;
    b[0] = 16'h7FF0; b[1] = 16'h7F7F; b[2] = 16'h8000; b[3] = 16'hFFFF;
    d[0] = 8'h7F;    d[1] = 8'h7F;    d[2] = 8'h7F;    d[3] = 8'h01;
    exp[0] = 16'h7FFF; exp[1] = 16'h7FFE; exp[2] = 16'h0000; exp[3] = 16'h0000;
    load_bias(b);
    window(d);
    tick(5);
    n_cmp++; if (f_valid !== 1'b1) begin n_bad++; $display("FAIL sat_valid: got %b want 1", f_valid); end
    for (int c = 0; c < OUT_CH; c++) begin
      n_cmp++;
      if (f_data[c] !== exp[c]) begin
        n_bad++; $display("FAIL saturate_ch%0d: got %h want %h", c, f_data[c], exp[c]);
      end
    end
  endtask

  task automatic test_full_frame;
    adc_vec_t d;
    load_bias('0);
    mon_start(1'b0);
    for (int i = 1; i <= 16; i++) begin
      for (int c = 0; c < OUT_CH; c++) d[c] = 8'(i);
      window(d);
      tick(10);
    end
    tick(20);
    n_cmp++; if (vs_cnt !== 1) begin n_bad++; $display("FAIL frame_vs_count: got %0d want 1", vs_cnt); end
    n_cmp++; if (first_v_cyc - vs_cyc !== 1) begin
      n_bad++; $display("FAIL frame_vs_lead: got %0d want 1", first_v_cyc - vs_cyc);
    end
    n_cmp++; if (v_cnt !== 16) begin n_bad++; $display("FAIL frame_valid_count: got %0d want 16", v_cnt); end
    n_cmp++; if (min_gap < 8) begin n_bad++; $display("FAIL frame_min_gap: got %0d want >=8", min_gap); end
    n_cmp++; if (fd_cnt !== 1) begin n_bad++; $display("FAIL frame_done_count: got %0d want 1", fd_cnt); end
    n_cmp++; if (fd_cyc !== last_v_cyc) begin
      n_bad++; $display("FAIL frame_done_align: got cycle %0d want %0d", fd_cyc, last_v_cyc);
    end
    n_cmp++; if (int'(dut_f.state) !== 0) begin
      n_bad++; $display("FAIL frame_end_idle: got state %0d want 0", int'(dut_f.state));
    end
    for (int i = 0; i < 16 && i < vq.size(); i++) begin
      n_cmp++;
      if (vq[i] !== 16'(i + 1)) begin n_bad++; $display("FAIL frame_order_%0d: got %0d want %0d", i, vq[i], i + 1); end
    end
  endtask

  task automatic test_overflow;
    adc_vec_t d;
    do_reset();
    load_bias('0);
    mon_start(1'b1);
    for (int i = 1; i <= 6; i++) begin
      d = '0; d[0] = 8'(i);
      window(d);
    end
    tick(2);
    n_cmp++; if (o_ovf !== 1'b0) begin n_bad++; $display("FAIL overflow_early: got %b want 0", o_ovf); end
    tick(1);
    n_cmp++; if (o_ovf !== 1'b1) begin n_bad++; $display("FAIL overflow_set: got %b want 1", o_ovf); end
    tick(200);
    n_cmp++; if (o_ovf !== 1'b1) begin n_bad++; $display("FAIL overflow_sticky: got %b want 1", o_ovf); end
    n_cmp++; if (v_cnt !== 5) begin n_bad++; $display("FAIL overflow_delivered: got %0d want 5", v_cnt); end
    n_cmp++; if (min_gap < 32) begin n_bad++; $display("FAIL overflow_pace: got %0d want >=32", min_gap); end
    for (int i = 0; i < 5 && i < vq.size(); i++) begin
      n_cmp++;
      if (vq[i] !== 16'(i + 1)) begin n_bad++; $display("FAIL overflow_order_%0d: got %0d want %0d", i, vq[i], i + 1); end
    end
  endtask

  task automatic test_push_pop_full;
    adc_vec_t d;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_cmp++; if (o_ovf !== 1'b0) begin n_bad++; $display("FAIL async_reset_overflow: got %b want 0", o_ovf); end
    n_cmp++; if (o_data !== '0) begin n_bad++; $display("FAIL async_reset_data: got %h want 0", o_data); end
    idle_inputs();
    tick(2);
    rstn = 1'b1;
    load_bias('0);
    mon_start(1'b1);
    for (int i = 11; i <= 15; i++) begin
      d = '0; d[0] = 8'(i);
      window(d);
    end
    tick(24);
    d = '0; d[0] = 8'd16;
    window(d);
    tick(3);
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL pp_pop_valid: got %b want 1", o_valid); end
    n_cmp++; if (o_data[0] !== 16'd12) begin n_bad++; $display("FAIL pp_pop_data: got %0d want 12", o_data[0]); end
    n_cmp++; if (o_ovf !== 1'b0) begin n_bad++; $display("FAIL pp_no_overflow: got %b want 0", o_ovf); end
    n_cmp++; if (int'(dut_o.count) !== 4) begin
      n_bad++; $display("FAIL pp_count: got %0d want 4", int'(dut_o.count));
    end
    tick(200);
    n_cmp++; if (v_cnt !== 6) begin n_bad++; $display("FAIL pp_delivered: got %0d want 6", v_cnt); end
    for (int i = 0; i < 6 && i < vq.size(); i++) begin
      n_cmp++;
      if (vq[i] !== 16'(i + 11)) begin n_bad++; $display("FAIL pp_order_%0d: got %0d want %0d", i, vq[i], i + 11); end
    end
  endtask

  task automatic test_flush;
    pix_vec_t b;
    adc_vec_t d;
    b = '0; b[0] = 16'd100;
    load_bias(b);
    mon_start(1'b1);
    for (int i = 1; i <= 4; i++) begin
      d = '0; d[0] = 8'(i);
      window(d);
    end
    tick(3);
    n_cmp++; if (v_cnt !== 1) begin n_bad++; $display("FAIL flush_pre_count: got %0d want 1", v_cnt); end
    vs_in = 1'b1;
    @(negedge clk);
    vs_in = 1'b0;
    n_cmp++; if (o_data !== '0) begin n_bad++; $display("FAIL flush_data_clear: got %h want 0", o_data); end
    tick(60);
    n_cmp++; if (v_cnt !== 1) begin n_bad++; $display("FAIL flush_no_output: got %0d want 1", v_cnt); end
    d = '0; d[0] = 8'd7;
    window(d);
    tick(4);
    n_cmp++; if (o_vs !== 1'b1) begin n_bad++; $display("FAIL flush_fresh_vs: got %b want 1", o_vs); end
    tick(1);
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL flush_fresh_valid: got %b want 1", o_valid); end
    n_cmp++; if (o_data[0] !== 16'd107) begin n_bad++; $display("FAIL flush_bias_kept: got %0d want 107", o_data[0]); end
  endtask

  initial begin
    test_reset();
    test_bias_relu();
    test_saturation();
    test_full_frame();
    test_overflow();
    test_push_pop_full();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
